rob_commit_unit: RTL and testbench
==================================

# rob_commit_unit

Commit stage that sits directly downstream of the reorder buffer and consumes its head entry. Each cycle it checks whether the head entry is complete, then retires it in program order. A register result is written to the architectural register file. A store is issued to data memory with a ready handshake, and the ROB head is held until the memory accepts it. The block also emits a retire strobe that the ROB uses to pop its head, plus a retired-instruction counter.

## Interface
- ADDR, 7, ROB tag width (ROB depth is 2**ADDR).
- CNT_W, 32, width of the retired-instruction counter.

- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- head_valid  in  1  ROB head entry is complete and retirable.
- empty  in  1  ROB is empty.
- head_tag  in  ADDR  ROB index of the head entry.
- RD_W  in  114  head entry, laid out as follows:
  - [113] valid
  - [112:108] destReg
  - [107:76] EX_result
  - [75:44] mem_WD
  - [43:32] control, with [32] RegWrite, [33] MemWrite, [34] Branch
  - [31:0] pc_plus4
- mem_ready  in  1  data memory accepts the pending store this cycle.
- retire  out  1  combinational pop strobe to the ROB.
- rf_WE  out  1  register-file write enable, registered.
- rf_WA  out  5  register-file write address, registered.
- rf_WD  out  32  register-file write data, registered.
- mem_req  out  1  store request, registered.
- mem_addr  out  32  store address, registered.
- mem_WD  out  32  store data, registered.
- commit_valid  out  1  an instruction retired last cycle, registered.
- commit_tag  out  ADDR  tag of that instruction.
- commit_pc  out  32  pc_plus4 of that instruction.
- retire_cnt  out  CNT_W  running count of retired instructions.

## Operation
- go = head_valid & ~empty. head_valid with empty=1 is ignored.
- Two-state FSM: IDLE and MEM_WAIT.
- In IDLE with go and MemWrite=0 (register write, branch, or other op):
  - retire=1 in the same cycle.
  - Back to IDLE.
- In IDLE with go and MemWrite=1:
  - retire=0.
  - Latch EX_result into mem_addr, mem_WD into mem_WD, and the full entry into an internal copy.
  - mem_req goes to 1 at the edge; next state is MEM_WAIT.
- In MEM_WAIT, mem_req=1 and the address and data stay stable. All other inputs are ignored.
- In MEM_WAIT with mem_ready=1:
  - retire=1 in the same cycle.
  - mem_req is cleared at the edge; next state is IDLE.
  - A new head is not examined until the following cycle, so there is at most one retire per cycle and no back-to-back store overlap.
- mem_ready while in IDLE is ignored.
- At every edge where retire=1, the retired entry (the live RD_W in IDLE, the latched copy in MEM_WAIT) drives these updates:
  - rf_WE is set to RegWrite & (destReg != 0) for exactly one cycle. A write to x0 is always suppressed.
  - rf_WA is set to destReg and rf_WD to EX_result. Both hold their value otherwise.
  - commit_valid=1 for one cycle, with commit_tag and commit_pc.
  - retire_cnt increments by 1 and wraps modulo 2**CNT_W.
- An entry with both MemWrite and RegWrite set is handled as a store, and the RF write happens when it retires.
- Branch entries retire like ALU entries with no RF write. Branch resolution is the execute stage's responsibility.

## Timing
- Reset values: state=IDLE; rf_WE, mem_req and commit_valid are 0; rf_WA, rf_WD, mem_addr, mem_WD, commit_tag, commit_pc and retire_cnt are 0; retire=0.
- Non-store latency: retire in cycle N, rf_WE in N+1. Throughput is 1 per cycle.
- Store latency:
  - go at N; mem_req high from N+1.
  - First mem_ready at cycle M ≥ N+1 gives retire=1 at M.
  - mem_req low and rf/commit outputs updated at M+1.
  - The earliest next retire is at M+1.
- A reset asserted mid-MEM_WAIT aborts the store:
  - mem_req drops immediately.
  - No retire, no counter increment, no RF write.

## Test plan
- Reset, then three consecutive reg entries (destReg 5, 6, 7; results 0x11, 0x22, 0x33) with head_valid=1:
  - retire=1 on three consecutive cycles.
  - rf_WE pulses carry WA/WD 5/0x11, 6/0x22, 7/0x33 one cycle later.
  - retire_cnt reaches 3.
- Reg entry with destReg=0 and RegWrite=1: retire=1, rf_WE stays 0, commit_valid=1, retire_cnt increments.
- Store with addr 0x100 and data 0xDEADBEEF, mem_ready low for 3 cycles then high:
  - mem_req held with stable addr and data for 4 cycles.
  - retire=1 only in the mem_ready cycle; mem_req=0 the next cycle.
- Store immediately followed by a reg entry at the head: the reg entry retires exactly one cycle after the store's retire cycle.
- Corner inputs:
  - head_valid=1 with empty=1: no retire.
  - mem_ready=1 pulsed while in IDLE: no effect.
  - retire_cnt preloaded near 2**CNT_W−1 (or CNT_W=4 with 17 retires): wraps to 0, then 1.
- rstn dropped 2 cycles into MEM_WAIT: mem_req=0 asynchronously, all outputs reach reset values. The same store, re-presented after reset, completes normally.

Source files
------------

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: in-order commit of the ROB head, holding stores until memory accepts them
module rob_commit_unit #(
  parameter int ADDR = 7,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             head_valid,
  input  logic             empty,
  input  logic [ADDR-1:0]  head_tag,
  input  logic [113:0]     RD_W,
  input  logic             mem_ready,
  output logic             retire,
  output logic             rf_WE,
  output logic [4:0]       rf_WA,
  output logic [31:0]      rf_WD,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_WD,
  output logic             commit_valid,
  output logic [ADDR-1:0]  commit_tag,
  output logic [31:0]      commit_pc,
  output logic [CNT_W-1:0] retire_cnt
);
  typedef enum logic {IDLE, MEM_WAIT} state_t;
  state_t state, next;
  logic [113:0] held;
  logic [ADDR-1:0] held_tag;
  logic [113:0] ent;
  logic [ADDR-1:0] tag;
  logic go, store, unused_bits;
  assign go = head_valid & ~empty;
  assign store = go & RD_W[33];
  // A parked store retires from its latched copy; the live head is ignored meanwhile
  assign ent = state == MEM_WAIT ? held : RD_W;
  assign tag = state == MEM_WAIT ? held_tag : head_tag;
  assign unused_bits = ^{ent[113], ent[43:33]};
  always_comb begin
    retire = state == IDLE ? go & ~RD_W[33] : mem_ready;
    next = state == IDLE ? (store ? MEM_WAIT : IDLE) : (mem_ready ? IDLE : MEM_WAIT);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      held <= '0;
      held_tag <= '0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      mem_WD <= '0;
      rf_WE <= 1'b0;
      rf_WA <= '0;
      rf_WD <= '0;
      commit_valid <= 1'b0;
      commit_tag <= '0;
      commit_pc <= '0;
      retire_cnt <= '0;
    end else begin
      state <= next;
      if (state == IDLE && store) begin
        held <= RD_W;
        held_tag <= head_tag;
        mem_addr <= RD_W[107:76];
        mem_WD <= RD_W[75:44];
        mem_req <= 1'b1;
      end else if (state == MEM_WAIT && mem_ready) begin
        mem_req <= 1'b0;
      end
      rf_WE <= retire & ent[32] & (|ent[112:108]);
      commit_valid <= retire;
      if (retire) begin
        rf_WA <= ent[112:108];
        rf_WD <= ent[107:76];
        commit_tag <= tag;
        commit_pc <= ent[31:0];
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_rob_commit_unit.sv
// tb_rob_commit_unit: scoreboard bench for the commit stage, narrow counter to exercise wrap
module tb_rob_commit_unit;
  localparam int CW = 4;
  logic clk = 0, rstn = 0, head_valid = 0, empty = 0, mem_ready = 0;
  logic [6:0] head_tag = 0;
  logic [113:0] RD_W = 0;
  logic retire, rf_WE, mem_req, commit_valid;
  logic [4:0] rf_WA;
  logic [31:0] rf_WD, mem_addr, mem_WD, commit_pc;
  logic [6:0] commit_tag;
  logic [CW-1:0] retire_cnt;
  typedef struct {logic we; logic [4:0] wa; logic [31:0] wd; logic [6:0] tag; logic [31:0] pc;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  logic [CW-1:0] exp_cnt = 0;

  rob_commit_unit #(.ADDR(7), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .head_valid(head_valid), .empty(empty), .head_tag(head_tag),
    .RD_W(RD_W), .mem_ready(mem_ready), .retire(retire), .rf_WE(rf_WE), .rf_WA(rf_WA),
    .rf_WD(rf_WD), .mem_req(mem_req), .mem_addr(mem_addr), .mem_WD(mem_WD),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_pc(commit_pc),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [113:0] mk(input logic [4:0] d, input logic [31:0] r, input logic [31:0] wd,
                                      input logic rw, input logic mw, input logic br, input logic [31:0] pc);
    return {1'b1, d, r, wd, 9'b0, br, mw, rw, pc};
  endfunction

  task automatic put(input logic [4:0] d, input logic [31:0] r, input logic [31:0] wd,
                     input logic rw, input logic mw, input logic [6:0] t, input logic [31:0] pc);
    head_valid = 1;
    empty = 0;
    head_tag = t;
    RD_W = mk(d, r, wd, rw, mw, 1'b0, pc);
    q.push_back('{rw && d != 0, d, r, t, pc});
  endtask

  always @(negedge clk) begin
    if (!rstn) exp_cnt = 0;
    else if (commit_valid) begin
      if (q.size() == 0) check("spurious_commit", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        exp_cnt = exp_cnt + 1'b1;
        check("rf_WE", rf_WE, e.we);
        check("rf_WA", rf_WA, e.wa);
        check("rf_WD", rf_WD, e.wd);
        check("commit_tag", commit_tag, e.tag);
        check("commit_pc", commit_pc, e.pc);
        check("retire_cnt", retire_cnt, exp_cnt);
      end
    end else check("rf_WE_idle", rf_WE, 0);
  end

  initial begin
    #12;
    check("rst_retire", retire, 0);
    check("rst_outs", {rf_WE, mem_req, commit_valid}, 0);
    check("rst_regs", {rf_WA, rf_WD, mem_addr, mem_WD}, 0);
    check("rst_commit", {commit_tag, commit_pc, retire_cnt}, 0);
    @(negedge clk); #1 rstn = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      put(5'(5 + i), 32'(17 * (i + 1)), 0, 1, 0, 7'(i), 32'h1000 + 32'(4 * i));
      #1 check("retire_reg", retire, 1);
    end
    @(negedge clk);
    put(0, 32'h44, 0, 1, 0, 3, 32'h2000);
    #1 check("retire_x0", retire, 1);
    @(negedge clk);
    head_valid = 0;
    mem_ready = 1;
    #1 check("idle_ready_retire", retire, 0);
    @(negedge clk);
    mem_ready = 0;
    head_valid = 1;
    empty = 1;
    RD_W = mk(4, 32'h99, 0, 1, 0, 0, 32'h3000);
    #1 check("idle_ready_req", mem_req, 0);
    check("empty_retire", retire, 0);
    @(negedge clk);
    put(9, 32'h100, 32'hDEADBEEF, 1, 1, 10, 32'h4000);
    #1 check("store_go_retire", retire, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      RD_W = mk(3, 32'h77, 32'h1234, 1, 0, 0, 32'h5000);
      head_tag = 99;
      mem_ready = (k == 3);
      #1 check("store_req", mem_req, 1);
      check("store_addr", mem_addr, 32'h100);
      check("store_data", mem_WD, 32'hDEADBEEF);
      check("store_retire", retire, k == 3);
    end
    @(negedge clk);
    mem_ready = 0;
    put(12, 32'h55, 0, 1, 0, 11, 32'h6000);
    #1 check("store_req_drop", mem_req, 0);
    check("after_store_retire", retire, 1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      put(5'(i + 1), 32'(i * 3), 0, 1, 0, 7'(i + 20), 32'h7000 + 32'(i));
      #1 check("wrap_retire", retire, 1);
    end
    @(negedge clk);
    head_valid = 0;
    @(negedge clk);
    #1 check("cnt_wrapped", retire_cnt, 2);
    put(0, 32'h200, 32'hCAFEF00D, 0, 1, 40, 32'h8000);
    @(negedge clk);
    @(negedge clk);
    #2 rstn = 0;
    q.delete();
    #1 check("abort_req", mem_req, 0);
    check("abort_retire", retire, 0);
    check("abort_outs", {rf_WE, commit_valid, rf_WA, rf_WD, mem_addr, mem_WD}, 0);
    check("abort_cnt", {commit_tag, commit_pc, retire_cnt}, 0);
    @(negedge clk); #1 rstn = 1;
    put(0, 32'h200, 32'hCAFEF00D, 0, 1, 40, 32'h8000);
    #1 check("re_go_retire", retire, 0);
    @(negedge clk);
    mem_ready = 1;
    #1 check("re_req", mem_req, 1);
    check("re_addr", mem_addr, 32'h200);
    check("re_retire", retire, 1);
    @(negedge clk);
    head_valid = 0;
    mem_ready = 0;
    #1 check("re_req_drop", mem_req, 0);
    @(negedge clk);
    #1 check("drain", q.size(), 0);
    check("re_cnt", retire_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
